// File: rtl/spi_ram_master_if.sv
// Host-side command/response bundle for spi_ram_master.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  // Host side: issues commands, receives responses.
  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  // SPI master side: consumes commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master: turns host RAM commands into 11-bit serial frames (one bit per
// clk) and returns the byte clocked in on MISO for read-data commands.
module spi_ram_master #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_master_if.slave host,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO
);

  localparam int CNT_MAX   = (TURNAROUND > IDLE_GAP) ? TURNAROUND : IDLE_GAP;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TURN_LAST = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam int GAP_LAST  = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  typedef enum logic [2:0] {IDLE, TX, TURN, RX, GAP} state_t;

  state_t          state, state_next;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   wait_cnt;
  logic [9:0]      shreg;
  logic [6:0]      rxreg;
  logic            rd_op;
  logic            accept, tx_last, turn_last, rx_last, gap_last;

  // Phase-end conditions shared by the FSM and the datapath.
  always_comb begin
    accept    = host.cmd_valid && (state == IDLE);
    tx_last   = (state == TX)   && (bit_cnt == 4'd10);
    turn_last = (state == TURN) && (wait_cnt == CW'(TURN_LAST));
    rx_last   = (state == RX)   && (bit_cnt == 4'd7);
    gap_last  = (state == GAP)  && (wait_cnt == CW'(GAP_LAST));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = TX;
      TX: begin
        if (tx_last) begin
          if (!rd_op)               state_next = GAP;
          else if (TURNAROUND == 0) state_next = RX;
          else                      state_next = TURN;
        end
      end
      TURN:    if (turn_last) state_next = RX;
      RX:      if (rx_last)   state_next = GAP;
      GAP:     if (gap_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state outputs.
  always_comb begin
    SS_n           = 1'b1;
    MOSI           = 1'b0;
    host.cmd_ready = 1'b0;
    host.busy      = 1'b1;
    unique case (state)
      IDLE: begin
        host.cmd_ready = 1'b1;
        host.busy      = 1'b0;
      end
      TX: begin
        SS_n = 1'b0;
        MOSI = shreg[9];
      end
      TURN, RX: SS_n = 1'b0;
      default: ;
    endcase
  end

  // Counters, shift/receive registers and response capture.
  // The first TX bit (control bit) equals cmd_op[1], which is already at the
  // MSB of the word, so the shift is skipped on bit 0 and the word MSB is sent
  // twice. The receive register keeps 7 bits: the 8th arrives straight from
  // MISO on the closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt        <= '0;
      wait_cnt       <= '0;
      shreg          <= '0;
      rxreg          <= '0;
      rd_op          <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
    end else begin
      host.rsp_valid <= 1'b0;
      bit_cnt  <= ((state == TX || state == RX) && state_next == state)
                  ? bit_cnt + 4'd1 : '0;
      wait_cnt <= ((state == TURN || state == GAP) && state_next == state)
                  ? wait_cnt + CW'(1) : '0;
      if (accept) begin
        shreg <= {host.cmd_op, host.cmd_data};
        rd_op <= (host.cmd_op == 2'b11);
      end else if (state == TX && bit_cnt != 4'd0) begin
        shreg <= {shreg[8:0], 1'b0};
      end
      if (state == RX) begin
        rxreg <= {rxreg[5:0], MISO};
        if (rx_last) begin
          host.rsp_valid <= 1'b1;
          host.rsp_data  <= {rxreg, MISO};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: a behavioural SPI RAM slave decodes
// MOSI frames and answers reads; a host-level RAM model predicts responses.
module tb_spi_ram_master;

  localparam int TA  = 2;
  localparam int TA3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss_n, mosi, miso;
  logic ss_n3, mosi3, miso3;

  spi_ram_master_if hif ();
  spi_ram_master_if hif3 ();

  spi_ram_master #(.TURNAROUND(TA), .IDLE_GAP(1)) dut (
    .clk(clk), .rst(rst), .host(hif), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_ram_master #(.TURNAROUND(TA3), .IDLE_GAP(1)) dut3 (
    .clk(clk), .rst(rst), .host(hif3), .SS_n(ss_n3), .MOSI(mosi3), .MISO(miso3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Host-level reference model of the RAM behind the wrapper.
  logic [7:0] mmem [256];
  logic [7:0] maddr;
  logic [7:0] last_rsp;

  // Slave-side RAM, seeded from the model after time 0.
  logic [7:0] smem [256];
  logic [7:0] saddr;

  // Behavioural SPI RAM slave: counts SS_n-low cycles, decodes 11-bit frames,
  // drives read data during the RX window and noise everywhere else.
  initial begin : slave
    int n;
    logic [10:0] fr;
    logic [7:0]  rb;
    logic        rd;
    n = 0; fr = '0; rb = '0; rd = 1'b0; miso = 1'b0; saddr = '0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) smem[i] = mmem[i];
    forever begin
      @(negedge clk);
      if (ss_n) begin
        n = 0;
        rd = 1'b0;
      end else begin
        n++;
        if (n <= 11) fr = {fr[9:0], mosi};
        if (n == 11) begin
          case (fr[9:8])
            2'b00: saddr = fr[7:0];
            2'b01: smem[saddr] = fr[7:0];
            2'b10: saddr = fr[7:0];
            default: begin
              rb = smem[saddr];
              rd = 1'b1;
            end
          endcase
        end
      end
      if (rd && n >= 12 + TA && n <= 19 + TA) miso = rb[19 + TA - n];
      else                                    miso = 1'($urandom);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_apply(input logic [1:0] op, input logic [7:0] d,
                             output logic [7:0] exp);
    exp = last_rsp;
    case (op)
      2'b00: maddr = d;
      2'b01: mmem[maddr] = d;
      2'b10: maddr = d;
      default: exp = mmem[maddr];
    endcase
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d, output bit ok);
    @(posedge clk); #1;
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    hif.cmd_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (hif.cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = 2'($urandom);
    hif.cmd_data  = 8'($urandom);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=0 required=1 within 100 cycles");
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {ss_n, mosi, hif.cmd_ready, hif.busy, hif.rsp_valid, hif.rsp_data, ss_n3};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_in: got=%b required=%b", got, {5'b10100, 8'h00, 1'b1});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      got = {ss_n, mosi, hif.cmd_ready, hif.busy, hif.rsp_valid, hif.rsp_data, ss_n3};
      checks++;
      if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL reset_idle: got=%b required=%b", got, {5'b10100, 8'h00, 1'b1});
      end
    end
    last_rsp = 8'h00;
  endtask

  // One complete frame, checked cycle by cycle against the frame timing.
  task automatic frame_check(input logic [1:0] op, input logic [7:0] d);
    logic [10:0] fr;
    logic [7:0]  exp;
    logic [12:0] got, want;
    int lowend, rspc, readyc;
    bit ok;
    fr = {op[1], op, d};
    model_apply(op, d, exp);
    lowend = (op == 2'b11) ? 19 + TA : 11;
    rspc   = (op == 2'b11) ? 20 + TA : 0;
    readyc = lowend + 2;
    send_cmd(op, d, ok);
    for (int k = 1; k <= readyc; k++) begin
      @(negedge clk);
      want = {k > lowend, (k <= 11) ? fr[11 - k] : 1'b0, k == readyc, k < readyc,
              k == rspc, (rspc != 0 && k >= rspc) ? exp : last_rsp};
      got  = {ss_n, mosi, hif.cmd_ready, hif.busy, hif.rsp_valid, hif.rsp_data};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame op=%b data=%h cycle=%0d: got ss/mosi/rdy/busy/rv=%b rd=%h required %b rd=%h",
                 op, d, k, got[12:8], got[7:0], want[12:8], want[7:0]);
      end
    end
    if (op == 2'b11) last_rsp = exp;
  endtask

  task automatic test_single_frame();
    frame_check(2'b00, 8'h5A);
  endtask

  task automatic test_ram_sequence();
    frame_check(2'b00, 8'h3C);
    frame_check(2'b01, 8'hA5);
    frame_check(2'b10, 8'h3C);
    frame_check(2'b11, 8'h00);
    for (int i = 0; i < 16; i++) frame_check(2'($urandom), 8'($urandom));
  endtask

  task automatic test_turnaround3(input logic [7:0] b);
    logic [4:0] got, want;
    bit ok;
    @(posedge clk); #1;
    hif3.cmd_valid = 1'b1;
    hif3.cmd_op    = 2'b11;
    hif3.cmd_data  = 8'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (hif3.cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1 hif3.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ta3_accept_timeout: cmd_ready=0 required=1");
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      want = {k >= 23, 1'b0, k == 24, k == 23, k < 24};
      got  = {ss_n3, (k >= 12) ? mosi3 : 1'b0, hif3.cmd_ready, hif3.rsp_valid, hif3.busy};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ta3_timing cycle=%0d: got ss/mosi/rdy/rv/busy=%b required=%b", k, got, want);
      end
      if (k == 23) begin
        checks++;
        if (hif3.rsp_data !== b) begin
          errors++;
          $display("FAIL ta3_rsp_data: got=%h required=%h", hif3.rsp_data, b);
        end
      end
      miso3 = (k >= 15 && k <= 22) ? b[22 - k] : 1'($urandom);
    end
  endtask

  // Four commands with cmd_valid held high throughout.
  task automatic test_back_to_back();
    logic [1:0] ops [4];
    logic [7:0] ds [4];
    int         lens [4];
    logic [7:0] rq [$];
    logic [7:0] exp;
    int idx = 0, nfr = 0, lowrun = 0, highrun = 0, viol = 0;
    logic prevss = 1'b1, prevrdy = 1'b1;
    bit done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 2'($urandom);
      ds[i]  = 8'($urandom);
      lens[i] = 0;
    end
    ops[1] = 2'b11;
    ops[2] = 2'b01;
    @(posedge clk); #1;
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = ops[0];
    hif.cmd_data  = ds[0];
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!ss_n) begin
        if (prevss) begin
          if (nfr > 0) begin
            checks++;
            if (highrun != 2) begin
              errors++;
              $display("FAIL b2b_gap frame=%0d: SS_n high %0d cycles, required 2", nfr, highrun);
            end
          end
          nfr++;
          lowrun = 0;
        end
        lowrun++;
        if (hif.cmd_ready) viol++;
      end else begin
        if (!prevss) begin
          checks++;
          if (lowrun != ((nfr >= 1 && nfr <= 4) ? lens[nfr - 1] : -1)) begin
            errors++;
            $display("FAIL b2b_frame_len frame=%0d: SS_n low %0d cycles, required %0d",
                     nfr, lowrun, (nfr >= 1 && nfr <= 4) ? lens[nfr - 1] : -1);
          end
          highrun = 0;
        end
        highrun++;
      end
      prevss = ss_n;
      if (hif.rsp_valid) begin
        exp = (rq.size() > 0) ? rq[0] : ~hif.rsp_data;
        checks++;
        if (hif.rsp_data !== exp) begin
          errors++;
          $display("FAIL b2b_rsp: got=%h required=%h (pending=%0d)", hif.rsp_data, exp, rq.size());
        end
        if (rq.size() > 0) void'(rq.pop_front());
      end
      if (idx < 4 && hif.cmd_ready && hif.cmd_valid) begin
        if (idx > 0) begin
          checks++;
          if (prevrdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_idle cmd=%0d: prior cycle cmd_ready=%b required=0", idx, prevrdy);
          end
        end
        model_apply(ops[idx], ds[idx], exp);
        if (ops[idx] == 2'b11) begin
          rq.push_back(exp);
          last_rsp = exp;
        end
        lens[idx] = (ops[idx] == 2'b11) ? 19 + TA : 11;
        @(posedge clk); #1;
        idx++;
        if (idx < 4) begin
          hif.cmd_op   = ops[idx];
          hif.cmd_data = ds[idx];
        end else begin
          hif.cmd_valid = 1'b0;
        end
        prevrdy = 1'b1;
      end else begin
        prevrdy = hif.cmd_ready;
      end
      if (idx == 4 && ss_n && highrun >= 3) done = 1'b1;
    end
    hif.cmd_valid = 1'b0;
    checks++;
    if (!done || idx != 4 || nfr != 4) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d frames=%0d done=%0d required 4/4/1", idx, nfr, done);
    end
    checks++;
    if (viol != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL b2b_ready_in_frame: ready-while-active=%0d missing-rsp=%0d required 0/0",
               viol, rq.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] got;
    int rvs = 0;
    bit ok;
    send_cmd(2'b11, 8'($urandom), ok);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    checks++;
    if (ss_n !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: SS_n=%b required=0", ss_n);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    got = {ss_n, mosi, hif.cmd_ready, hif.busy, hif.rsp_valid, hif.rsp_data};
    checks++;
    if (got !== {5'b10100, 8'h00}) begin
      errors++;
      $display("FAIL midreset_idle: got=%b required=%b", got, {5'b10100, 8'h00});
    end
    last_rsp = 8'h00;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (hif.rsp_valid || !ss_n) rvs++;
    end
    checks++;
    if (rvs != 0) begin
      errors++;
      $display("FAIL midreset_quiet: rsp_valid/SS_n activity in %0d cycles, required 0", rvs);
    end
    frame_check(2'b01, 8'($urandom));
    frame_check(2'b11, 8'($urandom));
  endtask

  initial begin : main
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mmem[i] = v;
    end
    maddr = '0;
    last_rsp = '0;
    hif.cmd_valid = 1'b0;  hif.cmd_op = '0;  hif.cmd_data = '0;
    hif3.cmd_valid = 1'b0; hif3.cmd_op = '0; hif3.cmd_data = '0;
    miso3 = 1'b0;
    rst = 1'b1;

    test_reset();
    test_single_frame();
    test_ram_sequence();
    test_turnaround3(8'hC3);
    test_turnaround3(8'($urandom));
    test_back_to_back();
    test_reset_midframe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
